// File: rtl/cpu_run_ctrl.sv
// Run-control and debug-scan unit for the pipelined CPU: reset sequencing, HALT/RUN/STEP clock enable,
// retired-cycle counter and debug register sweep. Define RUN_CTRL_BREAKPOINT_EN to add the PC breakpoint.
module cpu_run_ctrl #(
  parameter int RST_HOLD  = 4,
  parameter int STEP_W    = 16,
  parameter int DBG_AW    = 6,
  parameter int DBG_DEPTH = 32,
  parameter int DW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_count,
  output logic              cpu_rst,
  output logic              cpu_ce,
  output logic              halted,
  output logic              step_done,
  output logic [31:0]       cycle_cnt,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [DW-1:0]     bp_pc,
  input  logic [DW-1:0]     cur_pc,
  output logic              bp_hit,
`endif
  input  logic              dbg_scan_en,
  output logic [DBG_AW-1:0] dbg_addr,
  input  logic [DW-1:0]     dbg_data,
  output logic              snap_valid,
  output logic [DBG_AW-1:0] snap_addr,
  output logic [DW-1:0]     snap_data
);

  localparam int HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
  // A CPU_RESET command enters RESET_HOLD one cycle later than rst does, so it loads one less
  // to keep cpu_rst high for RST_HOLD cycles (at least one).
  localparam logic [HOLD_W-1:0] HOLD_CMD  = (RST_HOLD > 0) ? HOLD_W'(RST_HOLD - 1) : HOLD_W'(0);
  localparam logic [DBG_AW-1:0] DBG_LAST  = DBG_AW'(DBG_DEPTH - 1);

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  typedef enum logic [1:0] {
    ST_RESET_HOLD,
    ST_HALT,
    ST_RUN,
    ST_STEP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [STEP_W-1:0] remain;
  logic [STEP_W-1:0] remain_nxt;
  logic              step_done_nxt;
  logic              cnt_clr;
  logic              cmd_acc;
  logic              is_reset;
  logic              is_halt;
  logic              scan_act;
  logic              addr_clr;

  assign cmd_acc  = cmd_valid && cmd_ready;
  assign is_reset = cmd_acc && (cmd_op == OP_RESET);
  assign is_halt  = cmd_acc && (cmd_op == OP_HALT);
  assign scan_act = halted && dbg_scan_en;
  assign addr_clr = cnt_clr || ((state == ST_HALT) && (state_nxt != ST_HALT));

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_match;
  logic bp_hit_nxt;
  assign bp_match = cpu_ce && bp_en && (cur_pc == bp_pc);
`endif

  // Priority: CPU_RESET, then HALT command, then breakpoint, then step completion.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    remain_nxt    = remain;
    step_done_nxt = 1'b0;
    cnt_clr       = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    bp_hit_nxt    = 1'b0;
`endif
    if (state == ST_RESET_HOLD) begin
      if (hold_cnt == '0) begin
        state_nxt = ST_HALT;
      end else begin
        hold_nxt = hold_cnt - HOLD_W'(1);
      end
    end else if (is_reset) begin
      state_nxt = ST_RESET_HOLD;
      hold_nxt  = HOLD_CMD;
      cnt_clr   = 1'b1;
    end else if (state == ST_HALT) begin
      if (cmd_acc && (cmd_op == OP_RUN)) begin
        state_nxt = ST_RUN;
      end else if (cmd_acc && (cmd_op == OP_STEP)) begin
        state_nxt  = ST_STEP;
        remain_nxt = (cmd_count == '0) ? STEP_W'(1) : cmd_count;
      end
    end else if (is_halt) begin
      state_nxt = ST_HALT;
    end else begin
      if (state == ST_STEP) begin
        if (remain <= STEP_W'(1)) begin
          state_nxt     = ST_HALT;
          step_done_nxt = 1'b1;
        end else begin
          remain_nxt = remain - STEP_W'(1);
        end
      end
`ifdef RUN_CTRL_BREAKPOINT_EN
      if (bp_match) begin
        state_nxt  = ST_HALT;
        bp_hit_nxt = 1'b1;
      end
`endif
    end
  end

  // Every output is a flop loaded from the next state, so a command seen in cycle t shows up in t+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET_HOLD;
      hold_cnt   <= HOLD_INIT;
      remain     <= '0;
      cpu_rst    <= 1'b1;
      cpu_ce     <= 1'b0;
      cmd_ready  <= 1'b0;
      halted     <= 1'b0;
      step_done  <= 1'b0;
      cycle_cnt  <= '0;
      dbg_addr   <= '0;
      snap_valid <= 1'b0;
      snap_addr  <= '0;
      snap_data  <= '0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      bp_hit     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      remain    <= remain_nxt;
      cpu_rst   <= (state_nxt == ST_RESET_HOLD);
      cpu_ce    <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      cmd_ready <= (state_nxt != ST_RESET_HOLD);
      halted    <= (state_nxt == ST_HALT);
      step_done <= step_done_nxt;
`ifdef RUN_CTRL_BREAKPOINT_EN
      bp_hit    <= bp_hit_nxt;
`endif
      if (cnt_clr) begin
        cycle_cnt <= '0;
      end else if (cpu_ce) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end

      // The final halted sample is still captured even when the address is being cleared.
      snap_valid <= scan_act;
      if (scan_act) begin
        snap_addr <= dbg_addr;
        snap_data <= dbg_data;
      end
      if (addr_clr) begin
        dbg_addr <= '0;
      end else if (scan_act) begin
        dbg_addr <= (dbg_addr == DBG_LAST) ? '0 : dbg_addr + DBG_AW'(1);
      end
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesisable run-control and debug-scan unit for the pipelined CPU. It replaces free-running CPU clocking and manual reset with a commanded reset sequence, a clock-enable (cpu_ce) with HALT/RUN/STEP-N modes, a retired-cycle counter, and an automatic debug-register sweep while halted. It sits between the board/host command interface and the PCPU core's reset, clock-enable and debug_addr/debug_data ports.

Parameters:
RST_HOLD, 4, cycles cpu_rst stays high after rst falls or after a CPU_RESET command
STEP_W, 16, width of step count
DBG_AW, 6, debug address width
DBG_DEPTH, 32, number of debug addresses swept (1..2^DBG_AW)
DW, 32, debug data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 CPU_RESET
cmd_count  in  STEP_W  step count for STEP
cpu_rst  out  1  core reset
cpu_ce  out  1  core clock enable
halted  out  1  high in HALT state
step_done  out  1  one-cycle pulse when STEP completes
cycle_cnt  out  32  number of cpu_ce-high cycles
dbg_scan_en  in  1  enable debug sweep while halted
dbg_addr  out  DBG_AW  to core debug_addr
dbg_data  in  DW  from core debug_data (combinational in dbg_addr)
snap_valid  out  1  snapshot valid pulse
snap_addr  out  DBG_AW  address of snapshot
snap_data  out  DW  sampled debug data

Behaviour:
- All outputs registered. Reset: state RESET_HOLD, hold counter = RST_HOLD, cpu_rst=1, cpu_ce=0, cmd_ready=0, halted=0, step_done=0, cycle_cnt=0, dbg_addr=0, snap_valid=0, snap_addr=0, snap_data=0.
- RESET_HOLD: cpu_rst=1, cpu_ce=0, cmd_ready=0. Counter decrements each cycle; cpu_rst is high for exactly RST_HOLD cycles after rst falls (RST_HOLD=0: HALT on first cycle after rst). Then -> HALT.
- HALT: halted=1, cmd_ready=1, cpu_ce=0. Accepted ops: RUN -> RUN; STEP -> STEP with remaining=cmd_count (0 treated as 1); CPU_RESET -> RESET_HOLD; HALT -> no change.
- RUN: cpu_ce=1 every cycle, cmd_ready=1. HALT -> HALT; CPU_RESET -> RESET_HOLD; RUN/STEP accepted and ignored.
- STEP: cpu_ce=1, remaining decrements per cycle. Exactly N cpu_ce cycles, then HALT; step_done pulses in the first HALT cycle. HALT command aborts: no step_done. CPU_RESET -> RESET_HOLD. RUN/STEP ignored.
- Timing: command accepted in cycle t; new cpu_ce value appears in cycle t+1.
- CPU_RESET also clears cycle_cnt and dbg_addr. cycle_cnt increments on each cpu_ce=1 cycle and wraps at 2^32.
- Priority within one cycle: rst > CPU_RESET cmd > HALT cmd > breakpoint > step completion.
- Debug sweep: active when halted=1 and dbg_scan_en=1. dbg_addr advances by 1 per cycle, 0..DBG_DEPTH-1, then wraps to 0. Address a driven in cycle t gives snap_valid=1, snap_addr=a, snap_data=dbg_data(t) in cycle t+1.
- Sweep inactive: dbg_addr holds its value, snap_valid=0.
- Leaving HALT resets dbg_addr to 0. The sample of the final halted cycle is still delivered.

Optional Feature:
RUN_CTRL_BREAKPOINT_EN
- Defined: adds ports bp_en (in, 1), bp_pc (in, DW), cur_pc (in, DW), bp_hit (out, 1, reset 0).
- In RUN or STEP, a cycle with cpu_ce=1, bp_en=1 and cur_pc==bp_pc forces HALT next cycle (cpu_ce=0). bp_hit pulses for one cycle with the first halted cycle.
- If the match occurs on the final STEP cycle, step_done and bp_hit both pulse.
- Undefined: ports absent, no breakpoint logic.

Test Plan:
- Reset release with RST_HOLD=4 -> cpu_rst high exactly 4 cycles after rst falls, then halted=1, cmd_ready=1, cpu_ce=0, cycle_cnt=0.
- STEP count=5 from HALT -> cpu_ce high exactly 5 consecutive cycles starting the cycle after accept; step_done single pulse; cycle_cnt=5. STEP count=0 -> 1 cycle.
- RUN, then HALT after 100 cycles -> cycle_cnt=100, cpu_ce low the cycle after accept. HALT issued during STEP 10 at step 3 -> no step_done, cycle_cnt=3.
- Halted with dbg_scan_en=1, DBG_DEPTH=32, core returns data=addr*4 -> snap_valid every cycle, snap_addr 0..31 then 0, snap_data=snap_addr*4, one-cycle lag from dbg_addr.
- CPU_RESET during RUN -> cpu_ce=0 next cycle, cpu_rst high 4 cycles, cycle_cnt=0, dbg_addr=0, then HALT. Simultaneous rst mid-STEP -> full reset values.
- With RUN_CTRL_BREAKPOINT_EN, bp_pc=0x20, cur_pc incrementing by 4 per cpu_ce -> halt after the cycle with cur_pc=0x20; bp_hit one pulse; bp_en=0 -> no halt.
